// File: rtl/coverage_stall_watchdog.sv
// Coverage stall / round watchdog monitor: raises a latched, acknowledged interrupt
// with a cause code when coverage stops growing for a scaled window or a round overruns.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | disarmed; counters held at 0, prev_cov tracks cov
// RUN   | round in progress; stall and watchdog counters advance
// IRQ   | interrupt pending; counters frozen until ack or tohost done
// DONE  | round finished; waits for tohost[0] to drop before a new round
module coverage_stall_watchdog #(
    parameter int NCH         = 1,
    parameter int COV_W       = 30,
    parameter int CNT_W       = 32,
    parameter int BASE_WAIT   = 1000,
    parameter int SCALE_SHIFT = 19,
    parameter int WDOG_LIMIT  = 50000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NCH*COV_W-1:0]   cov,
    input  logic [63:0]            tohost,
    input  logic                   irq_ack,
    output logic                   interrupt,
    output logic [1:0]             irq_cause,
    output logic [CNT_W-1:0]       stall_count,
    output logic                   round_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_IRQ  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int              WW       = CNT_W + COV_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG_LIMIT);
    localparam logic [WW-1:0]    BASE_W   = WW'(BASE_WAIT);

    logic [1:0]             state;
    logic [NCH*COV_W-1:0]   prev_cov;
    logic [CNT_W-1:0]       wdog;
    logic [WW-1:0]          scaled;
    logic [WW-1:0]          window_wide;
    logic [CNT_W-1:0]       window;
    logic [CNT_W-1:0]       stall_inc;
    logic [CNT_W-1:0]       wdog_inc;
    logic                   progress;
    logic                   stall_hit;
    logic                   wdog_hit;
    logic                   done_bit;
    logic                   unused_tohost;

    assign done_bit      = tohost[0];
    assign unused_tohost = ^tohost[63:1];

    // Only channel 0 scales the window; the wide product cannot overflow WW bits.
    always_comb begin
        scaled      = (WW'(cov[COV_W-1:0]) >> SCALE_SHIFT) + WW'(1);
        window_wide = scaled * BASE_W;
        window      = (|window_wide[WW-1:CNT_W]) ? CNT_MAX : window_wide[CNT_W-1:0];
    end

    always_comb begin
        progress  = (cov != prev_cov);
        stall_hit = !progress && (stall_count >= window);
        wdog_hit  = (wdog >= WDOG_LIM);
        stall_inc = (stall_count == CNT_MAX) ? CNT_MAX : stall_count + CNT_W'(1);
        wdog_inc  = (wdog == CNT_MAX) ? CNT_MAX : wdog + CNT_W'(1);
    end

    // prev_cov can follow cov unconditionally: without progress the two are already equal.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            prev_cov    <= '0;
            stall_count <= '0;
            wdog        <= '0;
            interrupt   <= 1'b0;
            irq_cause   <= 2'b00;
            round_done  <= 1'b0;
        end else begin
            prev_cov   <= cov;
            round_done <= 1'b0;
            if (!enable) begin
                state       <= ST_IDLE;
                stall_count <= '0;
                wdog        <= '0;
                interrupt   <= 1'b0;
                irq_cause   <= 2'b00;
            end else begin
                case (state)
                    ST_IDLE: begin
                        stall_count <= '0;
                        wdog        <= '0;
                        state       <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (done_bit) begin
                            state       <= ST_DONE;
                            round_done  <= 1'b1;
                            stall_count <= '0;
                            wdog        <= '0;
                        end else if (stall_hit || wdog_hit) begin
                            state     <= ST_IRQ;
                            interrupt <= 1'b1;
                            irq_cause <= {wdog_hit, stall_hit};
                        end else begin
                            stall_count <= progress ? '0 : stall_inc;
                            wdog        <= wdog_inc;
                        end
                    end
                    ST_IRQ: begin
                        if (done_bit) begin
                            state       <= ST_DONE;
                            interrupt   <= 1'b0;
                            irq_cause   <= 2'b00;
                            round_done  <= 1'b1;
                            stall_count <= '0;
                            wdog        <= '0;
                        end else if (irq_ack) begin
                            state       <= ST_RUN;
                            interrupt   <= 1'b0;
                            irq_cause   <= 2'b00;
                            stall_count <= '0;
                            wdog        <= '0;
                        end
                    end
                    ST_DONE: begin
                        stall_count <= '0;
                        wdog        <= '0;
                        if (!done_bit) begin
                            state <= ST_RUN;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
